// File: rtl/uart_echo_buffer.sv
`default_nettype none
// ============================================================================
// Module      : uart_echo_buffer
// Description : Byte FIFO between uart_rx and uart_tx with a drain FSM that
//               retransmits buffered bytes in order, a sticky overflow flag
//               and a retriggerable activity strobe for an LED.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_echo_buffer #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int BLINK_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              overflow_clr,
  output logic              activity
);

  localparam int CNT_W = $clog2(BLINK_CYCLES + 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_ACK  = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  logic [7:0]       mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic [ADDR_W:0]  wr_ptr_nxt;
  logic [ADDR_W:0]  rd_ptr_nxt;
  logic [1:0]       state;
  logic [CNT_W-1:0] blink_cnt;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // A pop frees a slot in the same cycle, so a push while full is still
  // accepted when the drain FSM is taking a byte out at that moment.
  assign pop  = (state == ST_IDLE) && !empty && !tx_busy;
  assign push = rx_ready && (!full || pop);
  assign drop = rx_ready && full && !pop;

  assign wr_ptr_nxt = push ? wr_ptr + {{ADDR_W{1'b0}}, 1'b1} : wr_ptr;
  assign rd_ptr_nxt = pop  ? rd_ptr + {{ADDR_W{1'b0}}, 1'b1} : rd_ptr;

  // Storage array; no reset needed since only written slots are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= rx_data;
    end
  end

  // FIFO pointers and registered occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      level  <= wr_ptr_nxt - rd_ptr_nxt;
    end
  end

  // Sticky overflow: a new drop outranks a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  // Drain FSM: launch one byte, wait for the transmitter to accept and finish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            tx_data  <= mem[rd_ptr[ADDR_W-1:0]];
            tx_start <= 1'b1;
            state    <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (tx_busy) begin
            state <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Activity strobe: reloaded by every accepted byte, drops one cycle after
  // the hold counter has run down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      activity  <= 1'b0;
    end else if (push) begin
      blink_cnt <= CNT_W'(BLINK_CYCLES);
      activity  <= 1'b1;
    end else begin
      if (blink_cnt != '0) begin
        blink_cnt <= blink_cnt - CNT_W'(1);
      end
      activity <= (blink_cnt != '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_echo_buffer
// Description : Directed, self-checking bench for uart_echo_buffer with a
//               simple uart_tx busy model and a capture queue of sent bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_echo_buffer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int BLINK  = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready = 1'b0;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              overflow_clr = 1'b0;
  logic              activity;

  logic              hold = 1'b0;
  int                busy_cnt = 0;
  int                busy_len = 12500;
  int                starts = 0;
  int                peak = 0;
  logic [7:0]        got[$];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic            rx;
    logic            clr;
    logic            exp_ovf;
    logic [ADDR_W:0] exp_level;
    string           name;
  } vec_t;

  vec_t tbl[5];

  uart_echo_buffer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BLINK_CYCLES(BLINK)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .level(level), .overflow(overflow), .overflow_clr(overflow_clr),
    .activity(activity)
  );

  always #5 clk = ~clk;

  assign tx_busy = hold | (busy_cnt != 0);

  // uart_tx stand-in: captures each launched byte and stays busy busy_len cycles.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      busy_cnt = 0;
    end else if (tx_start) begin
      got.push_back(tx_data);
      busy_cnt = busy_len;
      starts++;
    end else if (busy_cnt != 0) begin
      busy_cnt--;
    end
    if (32'(level) > peak) peak = 32'(level);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] d);
    rx_data  = d;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_got(input int n, input int maxc, input string name);
    int c = 0;
    while (got.size() < n && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk(name, 32'(got.size()), 32'(n));
  endtask

  task automatic drain_idle(input string name);
    int c = 0;
    while ((level != 0 || tx_busy) && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk(name, {31'd0, (level == 0 && !tx_busy)}, 32'd1);
    tick(3);
  endtask

  // Single byte into an empty FIFO with TX idle: level, strobe and data timing.
  task automatic single_byte(input logic [7:0] d, input string tag);
    push_byte(d);
    chk({tag, " level N+1"}, 32'(level), 32'd1);
    chk({tag, " no start N+1"}, 32'(tx_start), 32'd0);
    @(negedge clk);
    chk({tag, " start N+2"}, 32'(tx_start), 32'd1);
    chk({tag, " data N+2"}, 32'(tx_data), 32'(d));
    @(negedge clk);
    chk({tag, " level N+3"}, 32'(level), 32'd0);
    chk({tag, " start drop N+3"}, 32'(tx_start), 32'd0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1, 5'd16, "drop sets ovf"};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 5'd16, "clr alone"};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 5'd16, "drop wins over clr"};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 5'd16, "ovf sticky"};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 5'd16, "clr later"};

    // Reset state
    tick(2);
    chk("rst tx_start", 32'(tx_start), 32'd0);
    chk("rst level", 32'(level), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    chk("rst activity", 32'(activity), 32'd0);
    chk("rst tx_data", 32'(tx_data), 32'd0);
    rst = 1'b0;
    tick(2);

    // 1: single byte, long transmitter busy, activity hold window
    starts = 0;
    got.delete();
    single_byte(8'h41, "t1");
    tick(BLINK + 1 - 3);
    chk("t1 activity held", 32'(activity), 32'd1);
    tick(1);
    chk("t1 activity expired", 32'(activity), 32'd0);
    drain_idle("t1 drain");
    chk("t1 one start", 32'(starts), 32'd1);
    chk("t1 byte", 32'(got.size() > 0 ? got[0] : 8'hxx), 32'h41);

    // 2: burst of 16, two cycles apart
    busy_len = 40;
    got.delete();
    peak = 0;
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i));
      tick(1);
    end
    wait_got(16, 3000, "t2 count");
    drain_idle("t2 drain");
    chk("t2 peak", {31'd0, (peak == 15 || peak == 16)}, 32'd1);
    chk("t2 overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t2 byte%0d", i), 32'(i < got.size() ? got[i] : 8'hxx), 32'(i));
    end

    // 3: 20 bytes with transmitter held busy
    hold = 1'b1;
    busy_len = 5;
    got.delete();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    chk("t3 level full", 32'(level), 32'd16);
    chk("t3 no ovf yet", 32'(overflow), 32'd0);
    tick(25);
    chk("t3 activity idle", 32'(activity), 32'd0);
    for (int i = 16; i < 20; i++) push_byte(8'(i));
    chk("t3 level stays", 32'(level), 32'd16);
    chk("t3 overflow", 32'(overflow), 32'd1);
    chk("t3 drop no activity", 32'(activity), 32'd0);
    hold = 1'b0;
    wait_got(16, 1000, "t3 count");
    tick(20);
    chk("t3 no extra", 32'(got.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t3 byte%0d", i), 32'(i < got.size() ? got[i] : 8'hxx), 32'(i));
    end
    drain_idle("t3 drain");

    // 4: push while full on the same cycle as a pop
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    chk("t4 ovf cleared", 32'(overflow), 32'd0);
    hold = 1'b1;
    got.delete();
    for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
    chk("t4 full", 32'(level), 32'd16);
    hold = 1'b0;
    rx_data = 8'hA5;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    hold = 1'b1;
    chk("t4 level kept", 32'(level), 32'd16);
    chk("t4 no ovf", 32'(overflow), 32'd0);
    chk("t4 start", 32'(tx_start), 32'd1);
    chk("t4 data", 32'(tx_data), 32'h20);
    tick(3);

    // 5: overflow set/clear table, FIFO full and drain stalled
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'hEE;
      rx_ready = tbl[i].rx;
      overflow_clr = tbl[i].clr;
      @(negedge clk);
      rx_ready = 1'b0;
      overflow_clr = 1'b0;
      chk({"t5 ", tbl[i].name, " ovf"}, 32'(overflow), 32'(tbl[i].exp_ovf));
      chk({"t5 ", tbl[i].name, " level"}, 32'(level), 32'(tbl[i].exp_level));
    end
    busy_len = 4;
    hold = 1'b0;
    wait_got(17, 1000, "t4 count");
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("t4 byte%0d", i), 32'(i < got.size() ? got[i] : 8'hxx),
          32'(i < 16 ? 8'h20 + i : 8'hA5));
    end
    drain_idle("t4 drain");

    // 6: async reset while waiting for TX done with 5 bytes queued
    busy_len = 50;
    got.delete();
    for (int i = 0; i < 6; i++) begin
      rx_data = 8'(8'h60 + i);
      rx_ready = 1'b1;
      @(negedge clk);
    end
    rx_ready = 1'b0;
    tick(1);
    chk("t6 level5", 32'(level), 32'd5);
    chk("t6 busy", 32'(tx_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6 rst start", 32'(tx_start), 32'd0);
    chk("t6 rst level", 32'(level), 32'd0);
    chk("t6 rst activity", 32'(activity), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    got.delete();
    single_byte(8'h55, "t6");
    wait_got(1, 200, "t6 count");
    drain_idle("t6 drain");
    chk("t6 no replay", 32'(got.size()), 32'd1);
    chk("t6 byte", 32'(got.size() > 0 ? got[0] : 8'hxx), 32'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
